// File: rtl/wb_frame_receiver_pkg.sv
// WBFrameReceiver: shared constants, register map and FSM states for the frame receiver
package WBFrameReceiver;
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam int FRAME_BITS = 27;
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_LEVEL   = 4;
  localparam int ST_ERRCNT  = 8;
  localparam int CTRL_CLR_OVR = 0;
  localparam int CTRL_CLR_ERR = 1;
  localparam int CTRL_FLUSH   = 2;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/wb_frame_receiver_fifo.sv
// wb_rx_fifo: synchronous frame FIFO with flush; a pop while full lets a simultaneous push in
module wb_rx_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  // occupancy flags and accepted-operation qualifiers
  always_comb begin
    empty = level == '0;
    full = level == LW'(DEPTH);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    dout = mem[rp];
  end
  // storage array, written only by accepted pushes
  always_ff @(posedge CLK_I) begin
    if (do_push & ~flush) mem[wp] <= din;
  end
  // pointers and level; flush behaves like reset
  always_ff @(posedge CLK_I) begin
    if (RST_I | flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      level <= (do_push & ~do_pop) ? level + LW'(1) : (do_pop & ~do_push) ? level - LW'(1) : level;
    end
  end
endmodule

// File: rtl/wb_frame_receiver.sv
// wb_frame_receiver: oversampling serial frame receiver with a Wishbone register interface
module wb_frame_receiver
  import WBFrameReceiver::*;
#(
  parameter int BIT_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SERIAL_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);
  localparam int CW = $clog2(BIT_DIV);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic s1, rx;
  rx_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [4:0] idx;
  logic [FRAME_BITS-1:0] sh, dout;
  logic tick, push_frame, bad_stop;
  logic req, rd, valid, pop, ctrl_wr, flush, clr_ovr, clr_err, fifo_push, set_ovr;
  logic overrun, frame_err, empty, full;
  logic [7:0] err_cnt;
  logic [LW-1:0] level;
  logic [31:0] status;
  logic [1:0] a;
  logic unused;
  assign unused = ^{ADR_I[31:2], DAT_I[31:3]};
  // two-flop synchronizer, idle-high after reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) {s1, rx} <= 2'b11;
    else {s1, rx} <= {SERIAL_I, s1};
  end
  // FSM state register
  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else state <= nxt;
  end
  // FSM next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = rx ? IDLE : START;
      START: nxt = tick ? (rx ? IDLE : DATA) : START;
      DATA:  nxt = (tick && idx == 5'd0) ? STOP : DATA;
      STOP:  nxt = tick ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // FSM outputs: sample strobe and stop-bit verdict
  always_comb begin
    tick = cnt == '0;
    push_frame = state == STOP && tick && rx;
    bad_stop = state == STOP && tick && !rx;
  end
  // bit timer, bit index and payload shift register
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      cnt <= (state == IDLE) ? CW'(BIT_DIV / 2 - 1) : tick ? CW'(BIT_DIV - 1) : cnt - CW'(1);
      if (state == START && tick) idx <= 5'(FRAME_BITS - 1);
      else if (state == DATA && tick) idx <= idx - 5'd1;
      if (state == DATA && tick) sh <= {sh[FRAME_BITS-2:0], rx};
    end
  end
  // Wishbone decode and read mux
  always_comb begin
    a = ADR_I[1:0];
    req = CYC_I & STB_I;
    rd = ~WE_I;
    valid = (a == ADR_DATA && rd && !empty) || (a == ADR_STATUS && rd) || a == ADR_CTRL;
    ACK_O = req & valid;
    ERR_O = req & ~valid;
    pop = req && rd && a == ADR_DATA && !empty;
    ctrl_wr = req && WE_I && a == ADR_CTRL;
    flush = ctrl_wr & DAT_I[CTRL_FLUSH];
    clr_ovr = ctrl_wr & DAT_I[CTRL_CLR_OVR];
    clr_err = ctrl_wr & DAT_I[CTRL_CLR_ERR];
    fifo_push = push_frame & ~flush;
    set_ovr = push_frame & full & ~pop & ~flush;
    status = {16'd0, err_cnt, 4'(level), frame_err, overrun, full, empty};
    DAT_O = !(ACK_O && rd) ? 32'd0 : a == ADR_DATA ? 32'(dout) : a == ADR_STATUS ? status : 32'd0;
  end
  // sticky error bits and saturating error counter; set beats clear
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      overrun <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      overrun <= set_ovr ? 1'b1 : clr_ovr ? 1'b0 : overrun;
      frame_err <= bad_stop ? 1'b1 : clr_err ? 1'b0 : frame_err;
      err_cnt <= clr_err ? 8'd0 : (bad_stop && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
  end
  wb_rx_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .push(fifo_push),
    .pop(pop),
    .flush(flush),
    .din(sh),
    .dout(dout),
    .empty(empty),
    .full(full),
    .level(level)
  );
endmodule

// File: tb/tb_wb_frame_receiver.sv
// tb_wb_frame_receiver: directed scenarios for the Wishbone frame receiver
module tb_wb_frame_receiver;
  localparam int BD = 16;
  logic clk = 1'b0;
  logic rst, ser, cyc, stb, we;
  logic [31:0] adr, dati, dato;
  logic ack, err;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] d;
  logic k, e;
  logic [26:0] pl [5];

  always #5 clk = ~clk;

  wb_frame_receiver #(.BIT_DIV(BD), .FIFO_DEPTH(4)) dut (
    .CLK_I(clk), .RST_I(rst), .SERIAL_I(ser), .CYC_I(cyc), .STB_I(stb), .WE_I(we),
    .ADR_I(adr), .DAT_I(dati), .DAT_O(dato), .ACK_O(ack), .ERR_O(err)
  );

  task automatic send_bit(input logic b);
    ser = b;
    repeat (BD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [26:0] p, input logic stop);
    send_bit(1'b0);
    for (int i = 26; i >= 0; i--) send_bit(p[i]);
    send_bit(stop);
    ser = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] wd,
                     output logic [31:0] rdat, output logic ak, output logic er);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {30'd0, a}; dati = wd;
    #1;
    rdat = dato; ak = ack; er = err;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dati = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ser = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dati = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({ack, err, dato} !== 34'd0) begin n_fail++; $display("FAIL idle_bus ack=%b err=%b dat=%h want 0", ack, err, dato); end
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1 || k !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL reset_status dat=%h ack=%b err=%b want 00000001/1/0", d, k, e); end
  endtask

  task automatic test_frame;
    send_frame({9'h1BC, 9'h0AA, 9'h055}, 1'b1);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL frame_level status=%h want 00000010", d); end
    bus(1'b0, 2'd0, 0, d, k, e);
    n_chk++;
    if (d !== 32'h06F1_5455 || k !== 1'b1) begin n_fail++; $display("FAIL frame_data dat=%h ack=%b want 06f15455/1", d, k); end
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL frame_empty status=%h want 00000001", d); end
  endtask

  task automatic test_glitch;
    ser = 1'b0;
    repeat (BD / 4) @(negedge clk);
    ser = 1'b1;
    repeat (2 * BD) @(negedge clk);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL glitch_status status=%h want 00000001", d); end
    send_frame(27'h0ABCDEF, 1'b1);
    bus(1'b0, 2'd0, 0, d, k, e);
    n_chk++;
    if (d !== 32'h00AB_CDEF) begin n_fail++; $display("FAIL glitch_recover dat=%h want 00abcdef", d); end
  endtask

  task automatic test_frame_err;
    send_frame(27'h1555555, 1'b0);
    repeat (2 * BD) @(negedge clk);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h109) begin n_fail++; $display("FAIL ferr_status status=%h want 00000109", d); end
    bus(1'b1, 2'd2, 32'h2, d, k, e);
    n_chk++;
    if (k !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL ctrl_ack ack=%b err=%b want 1/0", k, e); end
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ferr_clear status=%h want 00000001", d); end
  endtask

  task automatic test_overrun;
    pl[0] = 27'h1234567; pl[1] = 27'h7FFFFFF; pl[2] = 27'h0000001; pl[3] = 27'h4000000; pl[4] = 27'h2AAAAAA;
    for (int i = 0; i < 5; i++) send_frame(pl[i], 1'b1);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h46) begin n_fail++; $display("FAIL ovr_status status=%h want 00000046", d); end
    for (int i = 0; i < 4; i++) begin
      bus(1'b0, 2'd0, 0, d, k, e);
      n_chk++;
      if (d !== {5'd0, pl[i]} || k !== 1'b1) begin n_fail++; $display("FAIL ovr_read%0d dat=%h ack=%b want %h/1", i, d, k, {5'd0, pl[i]}); end
    end
    bus(1'b0, 2'd0, 0, d, k, e);
    n_chk++;
    if (d !== 32'h0 || k !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL empty_read dat=%h ack=%b err=%b want 0/0/1", d, k, e); end
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h5) begin n_fail++; $display("FAIL ovr_sticky status=%h want 00000005", d); end
    bus(1'b1, 2'd2, 32'h1, d, k, e);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ovr_clear status=%h want 00000001", d); end
  endtask

  task automatic test_bus_errors;
    bus(1'b1, 2'd0, 32'h1, d, k, e);
    n_chk++;
    if (k !== 1'b0 || e !== 1'b1) begin n_fail++; $display("FAIL wr_data ack=%b err=%b want 0/1", k, e); end
    bus(1'b0, 2'd3, 0, d, k, e);
    n_chk++;
    if (k !== 1'b0 || e !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL adr3 ack=%b err=%b dat=%h want 0/1/0", k, e, d); end
    bus(1'b0, 2'd2, 0, d, k, e);
    n_chk++;
    if (k !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL rd_ctrl ack=%b dat=%h want 1/0", k, d); end
  endtask

  task automatic test_flush;
    send_frame(27'h0000F0F, 1'b1);
    send_frame(27'h0F0F000, 1'b1);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h20) begin n_fail++; $display("FAIL flush_pre status=%h want 00000020", d); end
    bus(1'b1, 2'd2, 32'h4, d, k, e);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL flush_post status=%h want 00000001", d); end
  endtask

  task automatic test_reset_midframe;
    send_frame(27'h0333333, 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    rst = 1'b1; ser = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (BD) @(negedge clk);
    send_frame(27'h5A5A5A5, 1'b1);
    bus(1'b0, 2'd1, 0, d, k, e);
    n_chk++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL rst_level status=%h want 00000010", d); end
    bus(1'b0, 2'd0, 0, d, k, e);
    n_chk++;
    if (d !== 32'h05A5_A5A5) begin n_fail++; $display("FAIL rst_data dat=%h want 05a5a5a5", d); end
  endtask

  initial begin
    test_reset;
    test_frame;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_bus_errors;
    test_flush;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
